// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the boot-time program loader
package loader_pkg;

  // Loader sequencing: header bytes, then data words, then a sticky result
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Program memory is byte addressed; one instruction word per 4 bytes
  function automatic logic [31:0] byte_addr(input logic [15:0] word_idx);
    return {14'd0, word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in, program memory write port and status out
interface program_loader_if;

  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] mem_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  // Environment side: supplies the byte stream and start request
  modport master (
    output start, rx_data, rx_valid,
    input  mem_address, mem_write_enable, mem_write_data,
    input  busy, done, error, words_loaded
  );

  // Loader side
  modport slave (
    input  start, rx_data, rx_valid,
    output mem_address, mem_write_enable, mem_write_data,
    output busy, done, error, words_loaded
  );

endinterface

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs little-endian bytes into 32-bit words
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [23:0] lanes_q, lanes_d;
  logic [1:0]  idx_q, idx_d;

  // The top lane is never stored: the 4th byte is merged straight into the
  // output so the word is ready in the same cycle the byte arrives.
  assign word_o       = {byte_i, lanes_q};
  assign word_valid_o = valid_i && (idx_q == LAST_LANE);

  // Lane capture and byte index advance; clear restarts at lane 0
  always_comb begin
    lanes_d = lanes_q;
    idx_d   = idx_q;
    if (clear_i) begin
      idx_d = 2'd0;
    end else if (valid_i) begin
      case (idx_q)
        2'd0:    lanes_d[7:0]   = byte_i;
        2'd1:    lanes_d[15:8]  = byte_i;
        2'd2:    lanes_d[23:16] = byte_i;
        default: lanes_d        = lanes_q;
      endcase
      idx_d = idx_q + 2'd1;
    end
  end

  // Lane and index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lanes_q <= '0;
      idx_q   <= '0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - parses a length-prefixed image and writes it into program memory
module program_loader
  import loader_pkg::*;
#(
  parameter int DEPTH_WORDS    = 256,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);

  localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  // The ERROR state register adds a cycle, so trip one count early to make
  // error visible exactly TIMEOUT_CYCLES cycles after the last byte.
  localparam logic [TO_W-1:0] TO_TRIP   = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [16:0]     DEPTH_LIM = 17'(DEPTH_WORDS);

  loader_state_t   state_q, state_d;
  logic [15:0]     count_q, count_d;
  logic [15:0]     words_q, words_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;

  logic            loading;
  logic            start_go;
  logic            asm_valid;
  logic [31:0]     asm_word;
  logic            asm_word_valid;
  logic [15:0]     len_full;

  assign loading   = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) || (state_q == ST_DATA);
  assign start_go  = bus.start && !loading;
  assign asm_valid = bus.rx_valid && (state_q == ST_DATA);
  assign len_full  = {bus.rx_data, count_q[7:0]};

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (start_go),
    .valid_i      (asm_valid),
    .byte_i       (bus.rx_data),
    .word_o       (asm_word),
    .word_valid_o (asm_word_valid)
  );

  // Next-state, counters, timeout and registered write request
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    words_d = words_q;
    to_d    = to_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_go) begin
          state_d = ST_LEN_LO;
          count_d = '0;
          words_d = '0;
          to_d    = '0;
        end
      end
      ST_LEN_LO: begin
        if (bus.rx_valid) begin
          count_d = {8'd0, bus.rx_data};
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (bus.rx_valid) begin
          count_d = len_full;
          if (len_full == 16'd0) begin
            state_d = ST_DONE;
          end else if ({1'b0, len_full} > DEPTH_LIM) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (asm_word_valid) begin
          we_d    = 1'b1;
          addr_d  = byte_addr(words_q);
          wdata_d = asm_word;
          words_d = words_q + 16'd1;
          if (words_d == count_q) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (loading) begin
      if (bus.rx_valid) begin
        to_d = '0;
      end else if (to_q == TO_TRIP) begin
        state_d = ST_ERROR;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      words_q <= '0;
      to_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      words_q <= words_d;
      to_q    <= to_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // A strobe already registered when reset arrives must not reach memory
  assign bus.mem_write_enable = we_q && !reset;
  assign bus.mem_address      = addr_q;
  assign bus.mem_write_data   = wdata_q;
  assign bus.busy             = loading;
  assign bus.done             = (state_q == ST_DONE);
  assign bus.error            = (state_q == ST_ERROR);
  assign bus.words_loaded     = words_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;
  import loader_pkg::*;

  localparam int DEPTH = 256;
  localparam int TMO   = 16;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic        busy;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [7:0]  img[$];
  wr_t         obs[$];
  wr_t         exp_q[$];
  wr_t         mon_w;
  logic [31:0] mem_seen [int];
  logic [31:0] last_addr = '0;

  program_loader_if bus_if ();

  program_loader #(
    .DEPTH_WORDS    (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_if.mem_write_enable === 1'b1) begin
      mon_w.cyc  = cyc;
      mon_w.addr = bus_if.mem_address;
      mon_w.data = bus_if.mem_write_data;
      mon_w.done = bus_if.done;
      mon_w.busy = bus_if.busy;
      obs.push_back(mon_w);
      mem_seen[int'(bus_if.mem_address)] = bus_if.mem_write_data;
      last_addr = bus_if.mem_address;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, want);
  endtask

  task automatic check_outs_zero(input string pfx);
    check_eq({pfx, "_addr"},  bus_if.mem_address, 0);
    check_eq({pfx, "_we"},    bus_if.mem_write_enable, 0);
    check_eq({pfx, "_wdata"}, bus_if.mem_write_data, 0);
    check_eq({pfx, "_busy"},  bus_if.busy, 0);
    check_eq({pfx, "_done"},  bus_if.done, 0);
    check_eq({pfx, "_error"}, bus_if.error, 0);
    check_eq({pfx, "_words"}, bus_if.words_loaded, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pulse(input bit with_byte);
    bus_if.start = 1'b1;
    if (with_byte) begin
      bus_if.rx_valid = 1'b1;
      bus_if.rx_data  = 8'($urandom);
    end
    @(posedge clk);
    #1;
    bus_if.start    = 1'b0;
    bus_if.rx_valid = 1'b0;
    check_eq("busy_rise", bus_if.busy, 1);
  endtask

  task automatic compare_writes(input string pfx);
    int m;
    check_eq({pfx, "_nwr"}, obs.size(), exp_q.size());
    m = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check_eq($sformatf("%s_w%0d_cyc",  pfx, i), obs[i].cyc,  exp_q[i].cyc);
      check_eq($sformatf("%s_w%0d_addr", pfx, i), obs[i].addr, exp_q[i].addr);
      check_eq($sformatf("%s_w%0d_data", pfx, i), obs[i].data, exp_q[i].data);
      check_eq($sformatf("%s_w%0d_done", pfx, i), obs[i].done, exp_q[i].done);
      check_eq($sformatf("%s_w%0d_busy", pfx, i), obs[i].busy, exp_q[i].busy);
    end
    obs.delete();
    exp_q.delete();
  endtask

  // Drives img as one load and checks it against an image-level model
  task automatic run_load(input string pfx, input int gap_max, input bit with_byte, input bit strays);
    int  n;
    int  active;
    int  g;
    int  edges[$];
    wr_t w;
    n = int'({img[1], img[0]});
    active = (n > DEPTH) ? HDR_BYTES : HDR_BYTES + BYTES_PER_WORD * n;
    if (strays) repeat ($urandom_range(0, 2)) send_byte(8'($urandom));
    start_pulse(with_byte);
    for (int i = 0; i < img.size(); i++) begin
      g = $urandom_range(0, gap_max);
      for (int k = 0; k < g; k++) begin
        bus_if.start = strays && (i < active) && ($urandom_range(0, 3) == 0);
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
      end
      send_byte(img[i]);
      edges.push_back(cyc);
      if (i == 1 && n == 0)    check_eq({pfx, "_zl_done"}, bus_if.done, 1);
      if (i == 1 && n > DEPTH) check_eq({pfx, "_os_err"}, bus_if.error, 1);
    end
    idle(2);
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        w.cyc  = edges[HDR_BYTES + 4 * i + 3];
        w.addr = 32'(i * 4);
        w.data = {img[HDR_BYTES + 4 * i + 3], img[HDR_BYTES + 4 * i + 2],
                  img[HDR_BYTES + 4 * i + 1], img[HDR_BYTES + 4 * i]};
        w.done = (i == n - 1);
        w.busy = (i != n - 1);
        exp_q.push_back(w);
      end
    end
    compare_writes(pfx);
    check_eq({pfx, "_done"},  bus_if.done, (n <= DEPTH));
    check_eq({pfx, "_error"}, bus_if.error, (n > DEPTH));
    check_eq({pfx, "_busy"},  bus_if.busy, 0);
    check_eq({pfx, "_words"}, bus_if.words_loaded, (n <= DEPTH) ? n : 0);
  endtask

  initial begin
    int n;
    int sel;
    int hit;
    bus_if.start    = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    reset = 1'b1;
    idle(2);
    check_outs_zero("rst");
    reset = 1'b0;
    idle(1);

    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    run_load("nom", 0, 0, 0);
    check_eq("nom_mem0", mem_seen[0], 32'h00A00513);
    check_eq("nom_mem4", mem_seen[4], 32'h00B00593);

    img = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33};
    run_load("os", 1, 0, 0);
    img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("after_os", 1, 1, 1);
    check_eq("after_os_mem0", mem_seen[0], 32'hDEADBEEF);

    img = '{8'h00, 8'h00};
    run_load("zl", 2, 0, 1);

    img.delete();
    img.push_back(8'h00);
    img.push_back(8'h01);
    repeat (4 * DEPTH) img.push_back(8'($urandom));
    run_load("b2b", 0, 0, 0);
    check_eq("b2b_last_addr", last_addr, 32'h3FC);

    for (int r = 0; r < 10; r++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      n = 0;
      else if (sel == 1) n = $urandom_range(DEPTH + 1, 600);
      else               n = $urandom_range(1, 8);
      img.delete();
      img.push_back(n[7:0]);
      img.push_back(n[15:8]);
      if (n > DEPTH) repeat (3) img.push_back(8'($urandom));
      else repeat (4 * n) img.push_back(8'($urandom));
      run_load($sformatf("rnd%0d", r), 3, 1'($urandom_range(0, 1)), 1);
    end

    start_pulse(0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    hit = 0;
    for (int k = 1; k <= TMO + 4 && hit == 0; k++) begin
      @(negedge clk);
      if (bus_if.error === 1'b1) hit = k;
    end
    check_eq("tmo_cycles", hit, TMO);
    check_eq("tmo_busy", bus_if.busy, 0);
    check_eq("tmo_nwr", obs.size(), 0);
    obs.delete();
    #1;

    start_pulse(0);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    check_eq("mid_busy", bus_if.busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outs_zero("midrst");
    send_byte(8'h33);
    send_byte(8'h44);
    idle(2);
    check_eq("midrst_nwr", obs.size(), 0);
    check_eq("midrst_idle_busy", bus_if.busy, 0);
    obs.delete();

    img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_load("recover", 1, 0, 1);
    check_eq("recover_mem0", mem_seen[0], 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader that sits directly upstream of the program memory's write port. It takes a byte stream (from the UART receiver), parses a length-prefixed image, assembles little-endian 32-bit instruction words, and issues one write per word into program memory. While a load is in progress it holds the core in reset.

## Interface
- `DEPTH_WORDS`, default 256: program memory capacity in words. Images longer than this are rejected.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle gap between bytes while loading.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a load. Ignored while `busy`=1.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe. `rx_data` is valid in this cycle. A byte may arrive every cycle.
- `mem_address` out 32: byte address for program memory, equal to word_index<<2.
- `mem_write_enable` out 1: one-cycle write strobe.
- `mem_write_data` out 32: assembled instruction word.
- `busy` out 1: load in progress. Also drives the core's reset hold.
- `done` out 1: last load completed successfully. Sticky until the next `start`.
- `error` out 1: last load failed (oversize or timeout). Sticky until the next `start`.
- `words_loaded` out 16: number of words written in the current or last load.

## Operation
- **Image format:** 2-byte word count N (low byte first), followed by 4·N bytes. Each word is sent low byte first.
- **FSM states:** IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR.
- **Entering a load:** `start` in IDLE, DONE or ERROR moves to LEN_LO. It also clears `done`, `error`, `words_loaded`, the byte index and the timeout counter, and sets `busy`.
- **LEN_LO:** an accepted byte becomes count[7:0], then go to LEN_HI.
- **LEN_HI:** an accepted byte becomes count[15:8]. Then:
  - N=0 → DONE.
  - N>DEPTH_WORDS → ERROR.
  - otherwise → DATA.
- **DATA:**
  - A 2-bit byte index selects the lane: byte k goes to bits [8k+7:8k].
  - On the 4th byte, a write is issued at word index `words_loaded`, then `words_loaded` increments and the byte index wraps to 0.
  - When `words_loaded` reaches N → DONE.
- **Other states:** bytes arriving in IDLE, DONE or ERROR are discarded.
- **Timeout:** in LEN_LO, LEN_HI and DATA, the counter clears on each accepted byte and increments otherwise. Reaching TIMEOUT_CYCLES → ERROR.
- **On DONE or ERROR:** `busy` falls. A partial word is never written.
- **`start` while `busy`=1:** ignored. A load cannot be aborted except by `reset`.
- **`start` and `rx_valid` in the same cycle (not busy):** the byte is discarded. The length is taken from the next byte.
- **`reset` mid-load:** return to IDLE immediately. Memory already written is left as is. No write strobe is issued in the reset cycle or the cycle after it.

## Timing
- **Reset values:** all outputs 0 (`mem_address`, `mem_write_enable`, `mem_write_data`, `busy`, `done`, `error`, `words_loaded`). State is IDLE.
- **`busy`:** rises the cycle after `start`.
- **Write latency:** the write strobe, address and data are registered. `mem_write_enable`=1 for exactly one cycle, in the cycle after the 4th byte's `rx_valid`. `mem_address` and `mem_write_data` are stable in that cycle.
- **Throughput:** no back-pressure. Byte collection for the next word continues during the write cycle, so back-to-back bytes sustain one write every 4 cycles.
- **Completion:** `done` and the fall of `busy` occur in the same cycle as the final write strobe. This also applies for N=0 (cycle after the LEN_HI byte).
- **Timeout:** `error` rises TIMEOUT_CYCLES cycles after the last accepted byte, or after `start` if no byte arrives.
- **Widths:** `words_loaded` is 16-bit and never exceeds N. `mem_address` is zero-extended from {words_loaded, 2'b00}.

## Structure
- **Package `loader_pkg`:** state enum `loader_state_t`, the header length constant (2 bytes), and the bytes-per-word constant (4).
- **Sub-module `word_assembler`:**
  - Contains the byte-lane register and 2-bit index.
  - Inputs: byte, valid, clear.
  - Outputs: word, word_valid pulse.
- The FSM, counters and timeout stay in `program_loader`.

## Test plan
- **Nominal load:** `start`, then bytes 02 00 13 05 A0 00 93 05 B0 00 → writes 0x00A00513 @ addr 0x0, then 0x00B00593 @ addr 0x4. Each strobe lasts 1 cycle. Then `done`=1, `busy`=0, `words_loaded`=2.
- **Oversize:** N = 0x0101 (257) with `DEPTH_WORDS`=256 → `error`=1 after the LEN_HI byte, no writes. A following `start` with N=1 succeeds.
- **Timeout:** with `TIMEOUT_CYCLES`=16, send 01 00 AA then stop → `error`=1 exactly 16 cycles after the AA byte, no write, `busy`=0.
- **Back-to-back bytes and zero length:**
  - 256 words with `rx_valid` held high → 256 strobes, exactly 4 cycles apart, last address 0x3FC.
  - N=0 → `done`=1 the cycle after the LEN_HI byte.
- **Reset mid-word:** `reset` after 2 of 4 data bytes → all outputs 0 next cycle, no strobe. Stray bytes in IDLE and `start` while busy are both ignored.
